// File: rtl/led_pkg.sv
// Shared constants and types for the LED line PWM generator.
package led_pkg;

   localparam int unsigned N_CH   = 16;
   localparam int unsigned GRAY_W = 16;
   localparam int unsigned WCNT_W = $clog2(N_CH);
   localparam int unsigned HALF_W = GRAY_W / 2;

   localparam logic [GRAY_W-1:0] TC16 = 16'hFFFF;
   localparam logic [HALF_W-1:0] TC8  = 8'hFF;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/led_pwm_cmp.sv
// One channel's gray-depth select and PWM compare; result is registered by the top.
module led_pwm_cmp
   import led_pkg::*;
(
   input  logic              mode,
   input  logic [GRAY_W-1:0] cnt,
   input  logic [GRAY_W-1:0] gray,
   output logic              lit
);

   logic [GRAY_W-1:0] g_sel;
   logic [GRAY_W-1:0] c_sel;

   // 8-bit mode: upper gray byte against the low counter byte, both zero-extended
   assign g_sel = mode ? {{HALF_W{1'b0}}, gray[GRAY_W-1 -: HALF_W]} : gray;
   assign c_sel = mode ? {{HALF_W{1'b0}}, cnt[HALF_W-1:0]} : cnt;
   assign lit   = c_sel < g_sel;

endmodule

// File: rtl/led_pwm_gen.sv
// Double-buffered scan-line store plus per-channel PWM, one period per Vsync-high window.
module led_pwm_gen
   import led_pkg::*;
(
   input  logic              GCK,
   input  logic              rst,
   input  logic              Vsync,
   input  logic              mode,
   input  logic              pix_valid,
   input  logic [GRAY_W-1:0] pix_data,
   output logic              ready,
   output logic [N_CH-1:0]   OUT,
   output logic              line_done,
   output logic              underrun,
   output logic              overflow
);

   logic              vs_q;
   logic [WCNT_W-1:0] wcnt_q;
   logic              shadow_full_q;
   logic [GRAY_W-1:0] shadow_q [N_CH];
   logic [GRAY_W-1:0] active_q [N_CH];
   state_e            state_q;
   logic [GRAY_W-1:0] cnt_q;
   logic [N_CH-1:0]   out_q;
   logic [N_CH-1:0]   lit;
   logic              line_done_q;
   logic              underrun_q;
   logic              overflow_q;
   logic              rise;
   logic              tc;

   assign rise      = Vsync & ~vs_q;
   assign tc        = mode ? (cnt_q[HALF_W-1:0] == TC8) : (cnt_q == TC16);
   assign ready     = ~shadow_full_q;
   assign OUT       = out_q;
   assign line_done = line_done_q;
   assign underrun  = underrun_q;
   assign overflow  = overflow_q;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      led_pwm_cmp u_cmp (
         .mode (mode),
         .cnt  (cnt_q),
         .gray (active_q[k]),
         .lit  (lit[k])
      );
   end

   // Bank management runs independently of the PWM FSM.
   always_ff @(posedge GCK) begin
      if (rst) begin
         vs_q          <= 1'b0;
         wcnt_q        <= '0;
         shadow_full_q <= 1'b0;
         underrun_q    <= 1'b0;
         overflow_q    <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         vs_q <= Vsync;
         if (rise) begin
            shadow_full_q <= 1'b0;
            if (!shadow_full_q) underrun_q <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
               active_q[i] <= shadow_full_q ? shadow_q[i] : '0;
            end
            // a coincident word opens the next line instead of being dropped
            if (pix_valid) begin
               shadow_q[0] <= pix_data;
               wcnt_q      <= WCNT_W'(1);
            end else begin
               wcnt_q <= '0;
            end
         end else if (pix_valid) begin
            if (shadow_full_q) begin
               overflow_q <= 1'b1;
            end else begin
               shadow_q[wcnt_q] <= pix_data;
               if (wcnt_q == WCNT_W'(N_CH - 1)) begin
                  wcnt_q        <= '0;
                  shadow_full_q <= 1'b1;
               end else begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge GCK) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_q       <= '0;
         line_done_q <= 1'b0;
      end else begin
         line_done_q <= 1'b0;
         if (rise) begin
            state_q <= RUN;
            cnt_q   <= '0;
            out_q   <= '0;
         end else begin
            case (state_q)
               RUN: begin
                  if (Vsync) begin
                     out_q <= lit;
                     cnt_q <= mode ? {cnt_q[GRAY_W-1:HALF_W], cnt_q[HALF_W-1:0] + 1'b1}
                                   : cnt_q + 1'b1;
                     if (tc) begin
                        state_q     <= DONE;
                        line_done_q <= 1'b1;
                     end
                  end else begin
                     out_q   <= '0;
                     state_q <= IDLE;
                  end
               end
               DONE: begin
                  out_q <= '0;
                  if (!Vsync) state_q <= IDLE;
               end
               default: begin
                  out_q   <= '0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_pwm_gen.sv
// Directed, table-driven bench for led_pwm_gen: per-channel PWM shape, banking and flags.
module tb_led_pwm_gen;
   import led_pkg::*;

   logic        GCK = 1'b0;
   logic        rst;
   logic        Vsync;
   logic        mode;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        ready;
   logic [15:0] OUT;
   logic        line_done;
   logic        underrun;
   logic        overflow;

   typedef struct {
      logic [15:0] pix;
      int          exp_hi;
   } vec_t;

   vec_t tbl [17];
   int   exp_g  [16];
   int   hi_cnt [16];
   int   bad_cnt;
   int   ld_at;
   int   ld_num;
   int   n_chk  = 0;
   int   n_fail = 0;

   led_pwm_gen dut (
      .GCK       (GCK),
      .rst       (rst),
      .Vsync     (Vsync),
      .mode      (mode),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .ready     (ready),
      .OUT       (OUT),
      .line_done (line_done),
      .underrun  (underrun),
      .overflow  (overflow)
   );

   always #5 GCK = ~GCK;

   task automatic tick();
      @(posedge GCK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] w);
      pix_valid = 1'b1;
      pix_data  = w;
      tick();
      pix_valid = 1'b0;
   endtask

   task automatic load_tbl(input int n);
      for (int i = 0; i < n; i++) push(tbl[i].pix);
      for (int k = 0; k < 16; k++) exp_g[k] = tbl[k].exp_hi;
   endtask

   // Cycle c counts edges after the rise edge; channel k must be high exactly for c-1 < g.
   task automatic run_period(input int ncyc);
      bad_cnt = 0;
      ld_at   = 0;
      ld_num  = 0;
      for (int k = 0; k < 16; k++) hi_cnt[k] = 0;
      for (int c = 1; c <= ncyc; c++) begin
         tick();
         for (int k = 0; k < 16; k++) begin
            hi_cnt[k] += int'(OUT[k]);
            if (OUT[k] !== ((c - 1) < exp_g[k])) bad_cnt++;
         end
         if (line_done === 1'b1) begin
            ld_num++;
            if (ld_at == 0) ld_at = c;
         end
      end
   endtask

   task automatic check_hi(input string tag);
      for (int k = 0; k < 16; k++) check($sformatf("%s hi[%0d]", tag, k), hi_cnt[k], exp_g[k]);
      check({tag, " shape"}, bad_cnt, 0);
   endtask

   initial begin
      rst       = 1'b1;
      Vsync     = 1'b0;
      mode      = 1'b1;
      pix_valid = 1'b0;
      pix_data  = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst OUT", OUT, 0);
      check("rst line_done", line_done, 0);
      check("rst underrun", underrun, 0);
      check("rst overflow", overflow, 0);
      check("rst ready", ready, 1);

      // T1: 8-bit ramp, channel k lit for 16k cycles
      for (int k = 0; k < 16; k++) begin
         tbl[k].pix    = 16'((k * 16) << 8);
         tbl[k].exp_hi = k * 16;
      end
      load_tbl(16);
      check("t1 ready full", ready, 0);
      Vsync = 1'b1;
      tick();
      check("t1 OUT at rise", OUT, 0);
      check("t1 ready after rise", ready, 1);
      run_period(256);
      check_hi("t1");
      check("t1 ld_at", ld_at, 256);
      check("t1 ld_num", ld_num, 1);
      check("t1 underrun", underrun, 0);
      tick();
      check("t1 OUT in done", OUT, 0);
      check("t1 ld one-shot", line_done, 0);
      Vsync = 1'b0;
      tick();

      // T2: partial line -> underrun and dark period, then full 0xFF00 line
      for (int k = 0; k < 16; k++) begin
         tbl[k].pix    = 16'hFF00;
         tbl[k].exp_hi = 0;
      end
      load_tbl(5);
      Vsync = 1'b1;
      tick();
      run_period(256);
      check_hi("t2");
      check("t2 underrun", underrun, 1);
      check("t2 ld_at", ld_at, 256);
      Vsync = 1'b0;
      tick();
      for (int k = 0; k < 16; k++) tbl[k].exp_hi = 255;
      load_tbl(16);
      Vsync = 1'b1;
      tick();
      run_period(256);
      check_hi("t2b");
      check("t2b underrun sticky", underrun, 1);
      Vsync = 1'b0;
      tick();

      // T3: 17 words while idle, the last one dropped
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t3 underrun cleared", underrun, 0);
      for (int k = 0; k < 16; k++) begin
         tbl[k].pix    = 16'((k + 1) << 8);
         tbl[k].exp_hi = k + 1;
      end
      tbl[16].pix    = 16'hFF00;
      tbl[16].exp_hi = 0;
      load_tbl(16);
      check("t3 ready after 16", ready, 0);
      check("t3 overflow after 16", overflow, 0);
      push(tbl[16].pix);
      check("t3 overflow after 17", overflow, 1);
      Vsync = 1'b1;
      tick();
      check("t3 ready after rise", ready, 1);
      run_period(256);
      check_hi("t3");
      check("t3 underrun", underrun, 0);
      Vsync = 1'b0;
      tick();

      // T4: pix_valid coincident with the rise edge
      for (int k = 0; k < 16; k++) begin
         tbl[k].pix    = 16'h0300;
         tbl[k].exp_hi = 3;
      end
      load_tbl(16);
      pix_valid = 1'b1;
      pix_data  = 16'h0700;
      Vsync     = 1'b1;
      tick();
      pix_valid = 1'b0;
      check("t4 ready after rise", ready, 1);
      run_period(256);
      check_hi("t4");
      Vsync = 1'b0;
      tick();
      for (int i = 0; i < 14; i++) push(16'h0700);
      check("t4 ready after 15 words", ready, 1);
      push(16'h0700);
      check("t4 ready after 16 words", ready, 0);
      for (int k = 0; k < 16; k++) exp_g[k] = 7;
      Vsync = 1'b1;
      tick();
      run_period(256);
      check_hi("t4b");
      Vsync = 1'b0;
      tick();

      // T5: 16-bit mode, early Vsync fall at cycle 100
      mode = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tbl[k].pix    = (k == 3) ? 16'h0002 : 16'h0000;
         tbl[k].exp_hi = (k == 3) ? 2 : 0;
      end
      load_tbl(16);
      Vsync = 1'b1;
      tick();
      run_period(100);
      check_hi("t5");
      check("t5 no ld in run", ld_num, 0);
      Vsync = 1'b0;
      tick();
      check("t5 OUT after fall", OUT, 0);
      check("t5 ld after fall", line_done, 0);
      check("t5 state", 32'(dut.state_q), 32'(IDLE));

      // T6: reset mid-period
      mode = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tbl[k].pix    = 16'hFF00;
         tbl[k].exp_hi = 255;
      end
      load_tbl(16);
      Vsync = 1'b1;
      tick();
      run_period(50);
      check("t6 OUT lit", OUT, 32'hFFFF);
      check("t6 overflow before rst", overflow, 1);
      rst   = 1'b1;
      Vsync = 1'b0;
      tick();
      rst = 1'b0;
      check("t6 rst OUT", OUT, 0);
      check("t6 rst line_done", line_done, 0);
      check("t6 rst underrun", underrun, 0);
      check("t6 rst overflow", overflow, 0);
      check("t6 rst ready", ready, 1);
      Vsync = 1'b1;
      tick();
      check("t6 underrun", underrun, 1);
      for (int k = 0; k < 16; k++) exp_g[k] = 0;
      run_period(256);
      check_hi("t6");
      Vsync = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
